// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared constants for the memory-mapped output port
package mmio_pkg;

  localparam int BUS_W = 8;

  localparam logic [BUS_W-1:0] DEF_PORT_ADDR = 8'hFF;
  localparam logic [BUS_W-1:0] DEF_CTRL_ADDR = 8'hFE;

  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

endpackage

// File: rtl/mmio_fifo_mem.sv
// rtl/mmio_fifo_mem.sv - DEPTH x 8 register array, synchronous write, asynchronous read
module mmio_fifo_mem
  import mmio_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [BUS_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [BUS_W-1:0] rdata
);

  logic [BUS_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; contents are only meaningful behind the pointers.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_out_port.sv
// rtl/mmio_out_port.sv - snoops CPU stores into a FIFO stream; MMIO_OUT_DROP_CNT_EN adds drop_count
module mmio_out_port
  import mmio_pkg::*;
#(
  parameter int               DEPTH     = 8,
  parameter logic [BUS_W-1:0] PORT_ADDR = DEF_PORT_ADDR,
  parameter logic [BUS_W-1:0] CTRL_ADDR = DEF_CTRL_ADDR
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic [BUS_W-1:0]        address,
  input  logic [BUS_W-1:0]        data,
  output logic [BUS_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    overflow
`ifdef MMIO_OUT_DROP_CNT_EN
  ,
  output logic [7:0]              drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic push_req, ctrl_req, pop, flush, clr_ovf, do_push, drop;

  // Decode bus strobes and resolve push/pop/drop for this edge.
  always_comb begin
    push_req = we && (address == PORT_ADDR);
    ctrl_req = we && (address == CTRL_ADDR);
    flush    = ctrl_req && data[CTRL_FLUSH_BIT];
    clr_ovf  = ctrl_req && data[CTRL_CLR_OVF_BIT];
    pop      = out_valid && out_ready;
    // A full FIFO still accepts a store when the head leaves on the same edge.
    do_push  = push_req && (!full || pop) && !flush;
    drop     = push_req && full && !pop;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(pop);
    end
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Control state registers; reset empties the FIFO immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  mmio_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (do_push),
    .waddr (wr_ptr_q),
    .wdata (data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign overflow  = overflow_q;

`ifdef MMIO_OUT_DROP_CNT_EN
  logic [7:0] drop_count_q, drop_count_d;

  // Saturating count of dropped stores, cleared with the overflow flag.
  always_comb begin
    drop_count_d = drop_count_q;
    if (clr_ovf) begin
      drop_count_d = 8'd0;
    end else if (drop && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count_q <= 8'd0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_mmio_out_port.sv
// tb/tb_mmio_out_port.sv - self-checking bench for mmio_out_port
`timescale 1ns/1ps
module tb_mmio_out_port;

  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       we = 1'b0;
  logic [7:0] address = 8'h00;
  logic [7:0] data = 8'h00;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [3:0] count;
  logic       full;
  logic       overflow;
`ifdef MMIO_OUT_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  mmio_out_port #(.DEPTH(DEPTH), .PORT_ADDR(8'hFF), .CTRL_ADDR(8'hFE)) dut (
    .clock     (clock),
    .reset     (reset),
    .we        (we),
    .address   (address),
    .data      (data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
`ifdef MMIO_OUT_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a byte queue plus sticky flag and drop tally.
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  int         m_drops = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_drops = 0;
    end else begin
      int  sz;
      bit  pop;
      sz  = mq.size();
      pop = (sz > 0) && out_ready;
      if (we && address == 8'hFE && data[0]) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (we && address == 8'hFF) begin
          if (sz < DEPTH || pop) mq.push_back(data);
          else begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
          end
        end
      end
      if (we && address == 8'hFE && data[1]) begin
        m_ovf = 1'b0;
        m_drops = 0;
      end
    end
  end

  // Compare DUT outputs against the model every falling edge.
  always @(negedge clock) begin
    if (check_en) begin
      chk("cyc_count", int'(count), mq.size());
      chk("cyc_full", int'(full), int'(mq.size() == DEPTH));
      chk("cyc_valid", int'(out_valid), int'(mq.size() != 0));
      chk("cyc_ovf", int'(overflow), int'(m_ovf));
      if (mq.size() != 0) chk("cyc_data", int'(out_data), int'(mq[0]));
`ifdef MMIO_OUT_DROP_CNT_EN
      chk("cyc_drops", int'(drop_count), m_drops);
`endif
    end
  end

  task automatic cyc(input bit w, input logic [7:0] a, input logic [7:0] d, input bit r);
    @(negedge clock);
    #1;
    we = w; address = a; data = d; out_ready = r;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_en = 1'b1;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Single store and a store to an unrelated address.
    cyc(1'b1, 8'hFF, 8'h2A, 1'b0);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 'h2A);
    chk("t1_count", int'(count), 1);
    cyc(1'b1, 8'h10, 8'h33, 1'b0);
    chk("t1_other", int'(count), 1);
    idle_drain(1);
    chk("t1_empty", int'(out_valid), 0);

    // Overflow: nine stores into eight slots.
    for (int i = 1; i <= 9; i++) cyc(1'b1, 8'hFF, 8'(i), 1'b0);
    chk("t2_count", int'(count), 8);
    chk("t2_full", int'(full), 1);
    chk("t2_ovf", int'(overflow), 1);
`ifdef MMIO_OUT_DROP_CNT_EN
    chk("t2_drops", int'(drop_count), 1);
`endif
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain", int'(out_data), i);
      cyc(1'b0, 8'h00, 8'h00, 1'b1);
    end
    chk("t2_empty", int'(out_valid), 0);
    cyc(1'b1, 8'hFE, 8'h02, 1'b0);
    chk("t2_clr", int'(overflow), 0);

    // Store while full with a simultaneous pop.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'hFF, 8'(8'h10 + i), 1'b0);
    cyc(1'b1, 8'hFF, 8'h55, 1'b1);
    chk("t3_count", int'(count), 8);
    chk("t3_ovf", int'(overflow), 0);
    for (int i = 1; i < 8; i++) begin
      chk("t3_drain", int'(out_data), 8'h10 + i);
      cyc(1'b0, 8'h00, 8'h00, 1'b1);
    end
    chk("t3_last", int'(out_data), 'h55);
    idle_drain(1);

    // Flush with three bytes queued, then a fresh head.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF, 8'(8'hA0 + i), 1'b0);
    cyc(1'b1, 8'hFE, 8'h03, 1'b0);
    chk("t4_count", int'(count), 0);
    chk("t4_valid", int'(out_valid), 0);
    chk("t4_ovf", int'(overflow), 0);
    cyc(1'b1, 8'hFF, 8'h77, 1'b0);
    chk("t4_head", int'(out_data), 'h77);
    chk("t4_count1", int'(count), 1);
    idle_drain(1);

    // Streaming push/pop across two pointer wraps.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'hFF, 8'(8'h80 + i), 1'b1);
      chk("t5_count", int'(count <= 1), 1);
      chk("t5_data", int'(out_data), 8'h80 + i);
    end
    idle_drain(1);

    // Asynchronous reset between edges with five bytes queued.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hFF, 8'(8'hC0 + i), 1'b0);
    we = 1'b0;
    chk("t6_pre", int'(count), 5);
    reset = 1'b1;
    #1;
    chk("t6_count", int'(count), 0);
    chk("t6_valid", int'(out_valid), 0);
    #2;
    reset = 1'b0;
    cyc(1'b1, 8'hFF, 8'h99, 1'b0);
    chk("t6_after", int'(out_data), 'h99);
    chk("t6_cnt1", int'(count), 1);
    idle_drain(2);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
